// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci LFSR with seed load, lock-up guard and wrap indicator
//
// Purpose: pseudo-random pattern / scrambler state source. Advances STEPS
// single shifts per enabled clock, accepts a synchronous seed load, replaces
// an all-zero seed with RST_SEED, and flags when the state returns to the
// most recently accepted seed.
//
// Parameters:
//   WIDTH    state width, 3..32
//   TAPS     feedback mask, bit i set means state[i] feeds the XOR; bit WIDTH-1 must be set
//   STEPS    single shifts per enabled clock, 1..WIDTH
//   RST_SEED nonzero state used at reset and on lock-up recovery
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        advance state by STEPS shifts
//   ld        load ld_data (wins over en)
//   ld_data   seed value
//   po        registered LFSR state
//   wrap      one-cycle pulse when the state returns to the reference seed
//   lockup    one-cycle pulse when an all-zero load was rejected
//   step_cnt  enabled clocks since the last load, reset or wrap

module lfsr_gen #(
    parameter int unsigned           WIDTH    = 8,
    parameter logic [WIDTH-1:0]      TAPS     = 8'hB8,
    parameter int unsigned           STEPS    = 1,
    parameter logic [WIDTH-1:0]      RST_SEED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] po,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] step_cnt
);

    // Without the top tap the shift is not invertible and the state can
    // collapse to zero, so such a configuration is rejected.
    localparam logic TAPS_MSB = TAPS[WIDTH-1];

    always_comb begin : taps_check
        assert (TAPS_MSB) else $error("lfsr_gen: TAPS must have bit WIDTH-1 set");
    end

    logic [WIDTH-1:0] po_q,   po_d;
    logic [WIDTH-1:0] ref_q,  ref_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic             wrap_q, wrap_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] adv;

    // Unrolled chain of STEPS single shifts.
    always_comb begin
        adv = po_q;
        for (int s = 0; s < int'(STEPS); s++) begin
            adv = {adv[WIDTH-2:0], ^(adv & TAPS)};
        end
    end

    always_comb begin
        po_d   = po_q;
        ref_d  = ref_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        lock_d = 1'b0;
        if (ld) begin
            cnt_d = '0;
            if (ld_data == '0) begin
                // All-zero seed would lock the register; substitute the reset seed.
                po_d   = RST_SEED;
                ref_d  = RST_SEED;
                lock_d = 1'b1;
            end else begin
                po_d  = ld_data;
                ref_d = ld_data;
            end
        end else if (en) begin
            po_d = adv;
            if (adv == ref_q) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po_q   <= RST_SEED;
            ref_q  <= RST_SEED;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            po_q   <= po_d;
            ref_q  <= ref_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            lock_q <= lock_d;
        end
    end

    assign po       = po_q;
    assign wrap     = wrap_q;
    assign lockup   = lock_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed vector bench for lfsr_gen

module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, ld;
    logic [7:0] ld_data;
    logic [7:0] po, step_cnt;
    logic       wrap, lockup;

    logic       en2;
    logic [7:0] po2, step_cnt2;
    logic       wrap2, lockup2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_gen u_dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_data(ld_data),
        .po(po), .wrap(wrap), .lockup(lockup), .step_cnt(step_cnt)
    );

    lfsr_gen #(.STEPS(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .ld(1'b0), .ld_data(8'h00),
        .po(po2), .wrap(wrap2), .lockup(lockup2), .step_cnt(step_cnt2)
    );

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] ld_data;
        logic [7:0] po;
        logic       wrap;
        logic       lockup;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic e, logic l, logic [7:0] d, logic [7:0] p,
                                logic w, logic k, logic [7:0] c);
        vec_t v;
        v.en = e; v.ld = l; v.ld_data = d; v.po = p; v.wrap = w; v.lockup = k; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int wraps;

    initial begin
        //            en    ld    data   po     wrap  lock  cnt
        vecs[0]  = mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'd1);
        vecs[1]  = mk(1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 8'd2);
        vecs[2]  = mk(1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 8'd3);
        vecs[3]  = mk(1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 8'd4);
        vecs[4]  = mk(1'b1, 1'b0, 8'h00, 8'h23, 1'b0, 1'b0, 8'd5);
        vecs[5]  = mk(1'b1, 1'b0, 8'h00, 8'h47, 1'b0, 1'b0, 8'd6);
        vecs[6]  = mk(1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 8'd0);
        vecs[7]  = mk(1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'd0);
        vecs[8]  = mk(1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'd0);
        vecs[9]  = mk(1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 8'd0);
        vecs[10] = mk(1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 8'd0);
        vecs[11] = mk(1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 8'd0);
        vecs[12] = mk(1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 8'd0);
        vecs[13] = mk(1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'd1);
        vecs[14] = mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'd2);

        rst = 1'b1; en = 1'b0; ld = 1'b0; ld_data = 8'h00; en2 = 1'b0;
        #3;
        chk("reset_po",     32'(po),       32'h01);
        chk("reset_wrap",   32'(wrap),     32'h0);
        chk("reset_lockup", 32'(lockup),   32'h0);
        chk("reset_cnt",    32'(step_cnt), 32'h0);
        tick;
        rst = 1'b0;

        // STEPS = 2 instance from seed 01
        en2 = 1'b1;
        tick;
        chk("steps2_po1",  32'(po2),       32'h04);
        chk("steps2_cnt1", 32'(step_cnt2), 32'd1);
        tick;
        chk("steps2_po2",  32'(po2),       32'h11);
        chk("steps2_cnt2", 32'(step_cnt2), 32'd2);
        en2 = 1'b0;
        chk("steps1_idle_po", 32'(po), 32'h01);

        for (int i = 0; i < 15; i++) begin
            en = vecs[i].en; ld = vecs[i].ld; ld_data = vecs[i].ld_data;
            tick;
            chk($sformatf("vec%0d_po", i),     32'(po),       32'(vecs[i].po));
            chk($sformatf("vec%0d_wrap", i),   32'(wrap),     32'(vecs[i].wrap));
            chk($sformatf("vec%0d_lockup", i), 32'(lockup),   32'(vecs[i].lockup));
            chk($sformatf("vec%0d_cnt", i),    32'(step_cnt), 32'(vecs[i].cnt));
        end
        en = 1'b0; ld = 1'b0;

        // asynchronous reset mid-clock, no edge between assert and check
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_po",  32'(po),       32'h01);
        chk("midrst_cnt", 32'(step_cnt), 32'h0);
        // en/ld ignored while rst held across an edge
        en = 1'b1; ld = 1'b1; ld_data = 8'h33;
        tick;
        chk("rsthold_po", 32'(po), 32'h01);
        en = 1'b0; ld = 1'b0; ld_data = 8'h00;
        rst = 1'b0;
        tick;

        // period: seed 01, en held
        wraps = 0;
        en = 1'b1;
        for (int i = 1; i <= 510; i++) begin
            tick;
            if (wrap) wraps++;
            if (i == 254) begin
                chk("period_254_wrap", 32'(wrap),     32'h0);
                chk("period_254_cnt",  32'(step_cnt), 32'd254);
                chk("period_254_nwraps", 32'(wraps),  32'd0);
            end
            if (i == 255 || i == 510) begin
                chk($sformatf("period_%0d_wrap", i), 32'(wrap),     32'h1);
                chk($sformatf("period_%0d_po", i),   32'(po),       32'h01);
                chk($sformatf("period_%0d_cnt", i),  32'(step_cnt), 32'h0);
            end
            if (i == 256) chk("period_256_wrap_clear", 32'(wrap), 32'h0);
        end
        en = 1'b0;
        chk("period_total_wraps", 32'(wraps), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
